// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state encoding, phase-timer FSM
// encoding and phase classification helpers.
package wm_pkg;

    typedef enum logic [2:0] {
        STATE_START      = 3'd0,
        STATE_READY      = 3'd1,
        STATE_FILL_WATER = 3'd2,
        STATE_HEAT_WATER = 3'd3,
        STATE_WASH       = 3'd4,
        STATE_RINSE      = 3'd5,
        STATE_SPIN       = 3'd6,
        STATE_FAULT      = 3'd7
    } wm_state_e;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_DONE    = 2'd2,
        TMR_EXPIRED = 2'd3
    } tmr_state_e;

    // Phases that carry a time budget (sensor-terminated or fixed-length).
    function automatic logic is_timed_phase(input logic [2:0] s);
        return (s == STATE_FILL_WATER) || (s == STATE_HEAT_WATER) ||
               (s == STATE_WASH) || (s == STATE_RINSE) || (s == STATE_SPIN);
    endfunction

    function automatic logic is_sensor_phase(input logic [2:0] s);
        return (s == STATE_FILL_WATER) || (s == STATE_HEAT_WATER);
    endfunction

endpackage

// File: rtl/wm_phase_timer_if.sv
// Controller <-> phase-timer signal bundle. The controller side drives state and
// sensors; the timer side returns the phase-end pulses and progress.
interface wm_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       state;
    logic             sig_Full;
    logic             sig_Temperature;
    logic             sig_Cancel;
    logic             sig_Completed;
    logic             sig_Time_Out;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    modport master (
        output state, sig_Full, sig_Temperature, sig_Cancel,
        input  sig_Completed, sig_Time_Out, busy, remaining
    );

    modport slave (
        input  state, sig_Full, sig_Temperature, sig_Cancel,
        output sig_Completed, sig_Time_Out, busy, remaining
    );
endinterface

// File: rtl/wm_tick_prescaler.sv
// Divides the clock into timer ticks: counts 0..TICK_DIV-1 while enabled and
// flags the wrap cycle with a single-cycle tick.
module wm_tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Tick is combinational so the decrement lands on the same edge as the wrap.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timing scheduler: loads a per-phase budget on each phase entry and ends
// the phase with a one-cycle sig_Completed or sig_Time_Out pulse.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int CNT_W       = 16,
    parameter int FILL_TICKS  = 600,
    parameter int HEAT_TICKS  = 900,
    parameter int WASH_TICKS  = 1200,
    parameter int RINSE_TICKS = 600,
    parameter int SPIN_TICKS  = 300
) (
    input  logic           clock,
    input  logic           reset_n,
    wm_phase_timer_if.slave bus
);
    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    if (TICK_DIV < 1 ||
        longint'(FILL_TICKS)  > MAX_CNT || longint'(HEAT_TICKS) > MAX_CNT ||
        longint'(WASH_TICKS)  > MAX_CNT || longint'(RINSE_TICKS) > MAX_CNT ||
        longint'(SPIN_TICKS)  > MAX_CNT) begin : g_param_err
        $error("wm_phase_timer: TICK_DIV < 1 or a phase budget does not fit in CNT_W");
    end

    function automatic logic [CNT_W-1:0] phase_budget(input logic [2:0] s);
        case (s)
            STATE_FILL_WATER: return CNT_W'(FILL_TICKS);
            STATE_HEAT_WATER: return CNT_W'(HEAT_TICKS);
            STATE_WASH:       return CNT_W'(WASH_TICKS);
            STATE_RINSE:      return CNT_W'(RINSE_TICKS);
            STATE_SPIN:       return CNT_W'(SPIN_TICKS);
            default:          return '0;
        endcase
    endfunction

    tmr_state_e       fsm_q;
    logic [2:0]       prev_state_q;
    logic [2:0]       phase_q;
    logic [CNT_W-1:0] remaining_q;
    logic             completed_q;
    logic             timeout_q;
    logic             busy_q;

    logic entry;
    logic tick;
    logic sensor_hit;
    logic last_tick;

    assign entry      = (bus.state != prev_state_q);
    assign sensor_hit = ((phase_q == STATE_FILL_WATER) && bus.sig_Full) ||
                        ((phase_q == STATE_HEAT_WATER) && bus.sig_Temperature);
    // A zero budget ends the phase on the first RUN edge without waiting for a tick.
    assign last_tick  = (remaining_q == '0) || (tick && (remaining_q == CNT_W'(1)));

    wm_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (entry || bus.sig_Cancel),
        .enable  (fsm_q == TMR_RUN),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q        <= TMR_IDLE;
            prev_state_q <= STATE_START;
            phase_q      <= STATE_START;
            remaining_q  <= '0;
            completed_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            prev_state_q <= bus.state;
            completed_q  <= 1'b0;
            timeout_q    <= 1'b0;
            // Cancel outranks entry, so an entry seen during cancel is consumed.
            if (bus.sig_Cancel) begin
                fsm_q       <= TMR_IDLE;
                remaining_q <= '0;
                busy_q      <= 1'b0;
            end else if (entry) begin
                phase_q <= bus.state;
                if (is_timed_phase(bus.state)) begin
                    fsm_q       <= TMR_RUN;
                    remaining_q <= phase_budget(bus.state);
                    busy_q      <= 1'b1;
                end else begin
                    fsm_q       <= TMR_IDLE;
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                end
            end else if (fsm_q == TMR_RUN) begin
                if (sensor_hit) begin
                    fsm_q       <= TMR_DONE;
                    completed_q <= 1'b1;
                    busy_q      <= 1'b0;
                end else if (last_tick) begin
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                    if (is_sensor_phase(phase_q)) begin
                        fsm_q     <= TMR_EXPIRED;
                        timeout_q <= 1'b1;
                    end else begin
                        fsm_q       <= TMR_DONE;
                        completed_q <= 1'b1;
                    end
                end else if (tick) begin
                    remaining_q <= remaining_q - CNT_W'(1);
                end
            end
        end
    end

    assign bus.sig_Completed = completed_q;
    assign bus.sig_Time_Out  = timeout_q;
    assign bus.busy          = busy_q;
    assign bus.remaining     = remaining_q;

endmodule
